// File: rtl/regression_residual_checker.sv
// Residual checker: latches B0/B1, streams N points and emits e = y - (B0 + B1*x)
// plus a running sum of |e|. Define REG_ERR_SAT_EN to saturate yhat and e instead of wrapping.
module regression_residual_checker #(
    parameter int WIDTH     = 20,
    parameter int FRAC      = 10,
    parameter int N_SAMPLES = 150,
    parameter int ACC_WIDTH = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     inB0,
    input  logic [WIDTH-1:0]     inB1,
    input  logic [WIDTH-1:0]     inX,
    input  logic [WIDTH-1:0]     inY,
    input  logic                 inValid,
    output logic                 inReady,
    output logic [WIDTH-1:0]     outErr,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [ACC_WIDTH-1:0] sumAbsErr,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbgState
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends on ready, and the data is held stable while valid && !ready.

    localparam int CW = $clog2(N_SAMPLES + 1);
    localparam logic [CW-1:0] LAST = CW'(N_SAMPLES);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t              state, stateNext;
    logic                armed;
    logic [CW-1:0]       count;
    logic [WIDTH-1:0]    b0, b1;
    logic                startOk, accept, outFire;
    logic [2*WIDTH-1:0]  prod;
    logic [WIDTH-1:0]    t, err, absErr;
    logic                unusedProdBits;

    // Blocks a start that coincides with the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) armed <= 1'b0;
        else      armed <= 1'b1;
    end

    assign startOk = start && armed && (state != RUN);
    assign accept  = inValid && inReady;
    assign outFire = outValid && outReady;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: if (startOk) stateNext = RUN;
            RUN:        if (count == LAST && (!outValid || outReady)) stateNext = DONE;
            default:    stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == RUN);
        done     = (state == DONE);
        inReady  = (state == RUN) && (count < LAST) && (!outValid || outReady);
        dbgState = state;
    end

    assign prod           = $signed(b1) * $signed(inX);
    assign t              = prod[FRAC+WIDTH-1:FRAC];
    assign unusedProdBits = ^{prod[2*WIDTH-1:FRAC+WIDTH], prod[FRAC-1:0]};

`ifdef REG_ERR_SAT_EN
    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] v);
        if (v[WIDTH] != v[WIDTH-1])
            return v[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return v[WIDTH-1:0];
    endfunction

    logic [WIDTH:0]   yhatWide, errWide;
    logic [WIDTH-1:0] yhatSat;

    assign yhatWide = {b0[WIDTH-1], b0} + {t[WIDTH-1], t};
    assign yhatSat  = sat(yhatWide);
    assign errWide  = {inY[WIDTH-1], inY} - {yhatSat[WIDTH-1], yhatSat};
    assign err      = sat(errWide);
`else
    assign err = inY - (b0 + t);
`endif

    // Two's-complement negate maps the most negative value onto 2^(WIDTH-1) unsigned.
    assign absErr = err[WIDTH-1] ? (~err + 1'b1) : err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b0        <= '0;
            b1        <= '0;
            count     <= '0;
            outErr    <= '0;
            outValid  <= 1'b0;
            sumAbsErr <= '0;
        end else if (startOk) begin
            b0        <= inB0;
            b1        <= inB1;
            count     <= '0;
            outValid  <= 1'b0;
            sumAbsErr <= '0;
        end else if (accept) begin
            outErr    <= err;
            outValid  <= 1'b1;
            count     <= count + CW'(1);
            sumAbsErr <= sumAbsErr + ACC_WIDTH'(absErr);
        end else if (outFire) begin
            outValid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regression_residual_checker.sv
// Self-checking bench for regression_residual_checker: directed vectors plus randomized
// runs checked against an integer-arithmetic reference model and an expected queue.
module tb_regression_residual_checker;

    localparam int W    = 20;
    localparam int FRAC = 10;
    localparam int N    = 150;
    localparam int ACC  = 28;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   inB0 = '0, inB1 = '0, inX = '0, inY = '0;
    logic           inValid = 1'b0;
    logic           outReady = 1'b0;
    logic           inReady;
    logic [W-1:0]   outErr;
    logic           outValid;
    logic [ACC-1:0] sumAbsErr;
    logic           busy, done;
    logic [1:0]     dbgState;

    int             nChecks = 0;
    int             nFail = 0;
    logic [W-1:0]   expQ[$];
    longint         expSum;
    logic [W-1:0]   b0Cur, b1Cur;
    logic [W-1:0]   ptX[N];
    logic [W-1:0]   ptY[N];

    regression_residual_checker #(
        .WIDTH(W), .FRAC(FRAC), .N_SAMPLES(N), .ACC_WIDTH(ACC)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .inB0(inB0), .inB1(inB1), .inX(inX), .inY(inY),
        .inValid(inValid), .inReady(inReady),
        .outErr(outErr), .outValid(outValid), .outReady(outReady),
        .sumAbsErr(sumAbsErr), .busy(busy), .done(done), .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (plain integer arithmetic) ----------------
    function automatic longint wrapS(input longint v);
        longint m;
        m = v & ((longint'(1) << W) - 1);
        if (m >= (longint'(1) << (W-1))) m = m - (longint'(1) << W);
        return m;
    endfunction

    function automatic longint clampS(input longint v);
        longint hi, lo;
        hi = (longint'(1) << (W-1)) - 1;
        lo = -(longint'(1) << (W-1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint modelYhat(input logic [W-1:0] b0, input logic [W-1:0] b1,
                                         input logic [W-1:0] x);
        longint p, t, s;
        p = longint'($signed(b1)) * longint'($signed(x));
        t = wrapS(p >>> FRAC);
        s = longint'($signed(b0)) + t;
`ifdef REG_ERR_SAT_EN
        return clampS(s);
`else
        return wrapS(s);
`endif
    endfunction

    function automatic longint modelErr(input logic [W-1:0] b0, input logic [W-1:0] b1,
                                        input logic [W-1:0] x, input logic [W-1:0] y);
        longint s;
        s = longint'($signed(y)) - modelYhat(b0, b1, x);
`ifdef REG_ERR_SAT_EN
        return clampS(s);
`else
        return wrapS(s);
`endif
    endfunction

    function automatic logic [W-1:0] toBits(input longint v);
        return v[W-1:0];
    endfunction

    // ---------------- drivers ----------------
    task automatic doReset();
        rst = 1'b0; start = 1'b0; inValid = 1'b0; outReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
    endtask

    task automatic startRun(input logic [W-1:0] b0, input logic [W-1:0] b1);
        @(negedge clk);
        start = 1'b1; inB0 = b0; inB1 = b1;
        b0Cur = b0; b1Cur = b1;
        expSum = 0;
        expQ.delete();
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drivePoint(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        inValid = 1'b1; inX = x; inY = y; outReady = 1'b1;
        @(posedge clk);
        #1 inValid = 1'b0;
    endtask

    // Streams n points from ptX/ptY, scoreboarding every output handshake.
    task automatic runPoints(input int n, input bit randReady, input bit randValid,
                             output int cycles);
        int     sent;
        int     budget;
        bit     stop;
        longint e;
        logic [W-1:0] exp;
        sent = 0; budget = 40 * n + 100; stop = 0; cycles = 0;
        while (!stop) begin
            @(negedge clk);
            outReady = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (sent < n) begin
                inValid = randValid ? ($urandom_range(0, 3) != 0) : 1'b1;
                inX = ptX[sent]; inY = ptY[sent];
            end else begin
                inValid = 1'b0;
            end
            #1;
            if (outValid && outReady) begin
                nChecks++;
                if (expQ.size() == 0) begin
                    nFail++;
                    $display("FAIL stream_extra got %h exp none", outErr);
                end else begin
                    exp = expQ.pop_front();
                    if (outErr !== exp) begin
                        nFail++;
                        $display("FAIL stream_err got %h exp %h", outErr, exp);
                    end
                end
            end
            if (inValid && inReady) begin
                e = modelErr(b0Cur, b1Cur, inX, inY);
                expQ.push_back(toBits(e));
                expSum += (e < 0) ? -e : e;
                sent++;
            end
            @(posedge clk);
            cycles++;
            if (sent == n && expQ.size() == 0) stop = 1;
            else if (cycles >= budget) begin
                nChecks++; nFail++;
                $display("FAIL stream_timeout got %0d sent exp %0d", sent, n);
                stop = 1;
            end
        end
        #1 inValid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        doReset();
        @(negedge clk);
        nChecks++;
        if ({outErr, outValid, inReady, sumAbsErr, busy, done, dbgState} !== '0) begin
            nFail++;
            $display("FAIL reset_outputs got err=%h v=%b r=%b sum=%h busy=%b done=%b st=%0d exp all 0",
                     outErr, outValid, inReady, sumAbsErr, busy, done, dbgState);
        end
    endtask

    task automatic test_basic();
        doReset();
        startRun(20'h00400, 20'h00800);
        nChecks++;
        if (busy !== 1'b1) begin nFail++; $display("FAIL basic_busy got %b exp 1", busy); end
        drivePoint(20'h00C00, 20'h01E00);
        nChecks++;
        if (outValid !== 1'b1 || outErr !== 20'h00200) begin
            nFail++; $display("FAIL basic_err got v=%b %h exp 1 00200", outValid, outErr);
        end
        nChecks++;
        if (sumAbsErr !== 28'h200) begin
            nFail++; $display("FAIL basic_sum got %h exp 200", sumAbsErr);
        end
    endtask

    task automatic test_negative_slope();
        doReset();
        startRun(20'h00000, 20'hFFC00);
        drivePoint(20'h00800, 20'h00000);
        nChecks++;
        if (outValid !== 1'b1 || outErr !== 20'h00800) begin
            nFail++; $display("FAIL negslope_err got v=%b %h exp 1 00800", outValid, outErr);
        end
        nChecks++;
        if (sumAbsErr !== 28'h800) begin
            nFail++; $display("FAIL negslope_sum got %h exp 800", sumAbsErr);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0]   expErr;
        logic [ACC-1:0] expS;
`ifdef REG_ERR_SAT_EN
        expErr = 20'h80000; expS = 28'h80000;
`else
        expErr = 20'h00400; expS = 28'h400;
`endif
        doReset();
        startRun(20'h7FC00, 20'h00000);
        drivePoint(20'h00000, 20'h80000);
        nChecks++;
        if (outErr !== expErr) begin
            nFail++; $display("FAIL overflow_err got %h exp %h", outErr, expErr);
        end
        nChecks++;
        if (sumAbsErr !== expS) begin
            nFail++; $display("FAIL overflow_sum got %h exp %h", sumAbsErr, expS);
        end
    endtask

    task automatic test_backpressure();
        doReset();
        startRun(20'h00400, 20'h00800);
        @(negedge clk);
        inValid = 1'b1; inX = 20'h00C00; inY = 20'h01E00; outReady = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            inValid = 1'b1; inX = 20'h00400; inY = 20'h00000; outReady = 1'b0;
            #1;
            nChecks++;
            if (inReady !== 1'b0 || outValid !== 1'b1 || outErr !== 20'h00200) begin
                nFail++;
                $display("FAIL bp_stall%0d got r=%b v=%b %h exp 0 1 00200", i, inReady, outValid, outErr);
            end
        end
        @(negedge clk);
        outReady = 1'b1;
        #1;
        nChecks++;
        if (inReady !== 1'b1) begin nFail++; $display("FAIL bp_release got r=%b exp 1", inReady); end
        @(posedge clk);
        #1 inValid = 1'b0;
        nChecks++;
        if (outValid !== 1'b1 || outErr !== 20'hFF400) begin
            nFail++; $display("FAIL bp_next got v=%b %h exp 1 ff400", outValid, outErr);
        end
        nChecks++;
        if (sumAbsErr !== 28'hE00) begin
            nFail++; $display("FAIL bp_sum got %h exp e00", sumAbsErr);
        end
    endtask

    task automatic test_full_run();
        logic [W-1:0] b0, b1;
        int cycles;
        doReset();
        b0 = toBits(longint'($urandom_range(0, 65535)) - 32768);
        b1 = toBits(longint'($urandom_range(0, 8191)) - 4096);
        for (int i = 0; i < N; i++) begin
            ptX[i] = toBits(longint'($urandom_range(0, 32767)) - 16384);
            ptY[i] = toBits(modelYhat(b0, b1, ptX[i]) + 256);
        end
        startRun(b0, b1);
        runPoints(N, 1'b0, 1'b0, cycles);
        @(negedge clk);
        nChecks++;
        if (cycles !== N + 1) begin nFail++; $display("FAIL full_cycles got %0d exp %0d", cycles, N + 1); end
        nChecks++;
        if (sumAbsErr !== 28'h09600) begin nFail++; $display("FAIL full_sum got %h exp 09600", sumAbsErr); end
        nChecks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            nFail++; $display("FAIL full_done got done=%b busy=%b exp 1 0", done, busy);
        end
        repeat (3) @(negedge clk);
        nChecks++;
        if (sumAbsErr !== 28'h09600 || done !== 1'b1) begin
            nFail++; $display("FAIL full_hold got sum=%h done=%b exp 09600 1", sumAbsErr, done);
        end
    endtask

    task automatic test_random();
        int cycles;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                ptX[i] = W'($urandom());
                ptY[i] = W'($urandom());
            end
            startRun(W'($urandom()), W'($urandom()));
            runPoints(N, 1'b1, 1'b1, cycles);
            @(negedge clk);
            nChecks++;
            if (sumAbsErr !== expSum[ACC-1:0]) begin
                nFail++; $display("FAIL random%0d_sum got %h exp %h", r, sumAbsErr, expSum[ACC-1:0]);
            end
            nChecks++;
            if (done !== 1'b1) begin nFail++; $display("FAIL random%0d_done got %b exp 1", r, done); end
        end
    endtask

    task automatic test_reset_mid_run();
        int cycles;
        doReset();
        for (int i = 0; i < N; i++) begin
            ptX[i] = W'($urandom());
            ptY[i] = W'($urandom());
        end
        startRun(W'($urandom()), W'($urandom()));
        runPoints(40, 1'b0, 1'b0, cycles);
        #2 rst = 1'b0;
        #1;
        nChecks++;
        if ({outErr, outValid, inReady, sumAbsErr, busy, done, dbgState} !== '0) begin
            nFail++;
            $display("FAIL midreset_outputs got err=%h v=%b r=%b sum=%h busy=%b done=%b st=%0d exp all 0",
                     outErr, outValid, inReady, sumAbsErr, busy, done, dbgState);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nChecks++;
        if (busy !== 1'b0) begin nFail++; $display("FAIL start_at_release got busy=%b exp 0", busy); end
        startRun(W'($urandom()), W'($urandom()));
        runPoints(N, 1'b1, 1'b0, cycles);
        @(negedge clk);
        nChecks++;
        if (sumAbsErr !== expSum[ACC-1:0] || done !== 1'b1) begin
            nFail++; $display("FAIL midreset_rerun got sum=%h done=%b exp %h 1", sumAbsErr, done, expSum[ACC-1:0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative_slope();
        test_overflow();
        test_backpressure();
        test_full_run();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
